// File: rtl/pr_update_tx.sv
// Predictor-update transmitter: queues up to two resolved branches per cycle, emits one update per cycle,
// and pulses a restart with the corrected PC on mispredict. Optional counters under PR_UPDATE_TX_STATS_EN.
module pr_update_tx #(
  parameter int DEPTH    = 8,
  parameter int PC_BITS  = 32,
  parameter int IN_WIDTH = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [IN_WIDTH-1:0]         res_valid_i,
  output logic                        res_ready_o,
  input  logic [IN_WIDTH*PC_BITS-1:0] res_orig_pc_i,
  input  logic [IN_WIDTH*PC_BITS-1:0] res_target_i,
  input  logic [IN_WIDTH-1:0]         res_taken_i,
  input  logic [IN_WIDTH-1:0]         res_pred_taken_i,
  input  logic [IN_WIDTH*PC_BITS-1:0] res_pred_target_i,
  input  logic [IN_WIDTH-1:0]         res_is_comp_i,
  input  logic [IN_WIDTH*2-1:0]       res_rat_id_i,
  input  logic                        flush_i,
  output logic                        pr_valid_jump_o,
  output logic                        pr_jump_taken_o,
  output logic                        pr_is_comp_o,
  output logic [1:0]                  pr_rat_id_o,
  output logic [PC_BITS-1:0]          pr_orig_pc_o,
  output logic [PC_BITS-1:0]          pr_jump_address_o,
  output logic [2:0]                  pr_ticket_o,
  output logic                        restart_o,
  output logic [PC_BITS-1:0]          restart_pc_o
`ifdef PR_UPDATE_TX_STATS_EN
  ,
  output logic [31:0]                 stat_updates_o,
  output logic [31:0]                 stat_mispred_o
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PC_BITS-1:0] mem_pc   [DEPTH];
  logic [PC_BITS-1:0] mem_tgt  [DEPTH];
  logic [PC_BITS-1:0] mem_ptgt [DEPTH];
  logic               mem_tk   [DEPTH];
  logic               mem_ptk  [DEPTH];
  logic               mem_comp [DEPTH];
  logic [1:0]         mem_rat  [DEPTH];

  logic [PW-1:0] rd_ptr, wr_ptr, wr_ptr1;
  logic [CW-1:0] count;
  logic [2:0]    ticket;
  logic          pop, mis, push_ok;
  logic [1:0]    n_push;

  logic [PC_BITS-1:0] head_pc, head_tgt, head_ptgt;
  logic               head_tk, head_ptk, head_comp;
  logic [1:0]         head_rat;

  assign head_pc   = mem_pc[rd_ptr];
  assign head_tgt  = mem_tgt[rd_ptr];
  assign head_ptgt = mem_ptgt[rd_ptr];
  assign head_tk   = mem_tk[rd_ptr];
  assign head_ptk  = mem_ptk[rd_ptr];
  assign head_comp = mem_comp[rd_ptr];
  assign head_rat  = mem_rat[rd_ptr];

  assign res_ready_o = (count <= CW'(DEPTH - 2));
  assign pop         = (count != '0) && !flush_i;
  assign mis         = pop && ((head_tk != head_ptk) || (head_tk && (head_tgt != head_ptgt)));
  // a mispredict squashes the wrong path, including anything arriving this cycle
  assign push_ok     = res_ready_o && !flush_i && !mis;
  assign n_push      = push_ok ? ({1'b0, res_valid_i[0]} + {1'b0, res_valid_i[1]}) : 2'd0;
  assign wr_ptr1     = wr_ptr + PW'(res_valid_i[0]);

  always_ff @(posedge clk) begin
    if (push_ok && res_valid_i[0]) begin
      mem_pc[wr_ptr]   <= res_orig_pc_i[0 +: PC_BITS];
      mem_tgt[wr_ptr]  <= res_target_i[0 +: PC_BITS];
      mem_ptgt[wr_ptr] <= res_pred_target_i[0 +: PC_BITS];
      mem_tk[wr_ptr]   <= res_taken_i[0];
      mem_ptk[wr_ptr]  <= res_pred_taken_i[0];
      mem_comp[wr_ptr] <= res_is_comp_i[0];
      mem_rat[wr_ptr]  <= res_rat_id_i[0 +: 2];
    end
    if (push_ok && res_valid_i[1]) begin
      mem_pc[wr_ptr1]   <= res_orig_pc_i[PC_BITS +: PC_BITS];
      mem_tgt[wr_ptr1]  <= res_target_i[PC_BITS +: PC_BITS];
      mem_ptgt[wr_ptr1] <= res_pred_target_i[PC_BITS +: PC_BITS];
      mem_tk[wr_ptr1]   <= res_taken_i[1];
      mem_ptk[wr_ptr1]  <= res_pred_taken_i[1];
      mem_comp[wr_ptr1] <= res_is_comp_i[1];
      mem_rat[wr_ptr1]  <= res_rat_id_i[2 +: 2];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= rd_ptr;
      count  <= '0;
    end else if (mis) begin
      rd_ptr <= rd_ptr + PW'(1);
      wr_ptr <= rd_ptr + PW'(1);
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PW'(pop);
      wr_ptr <= wr_ptr + PW'(n_push);
      count  <= count - CW'(pop) + CW'(n_push);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ticket <= '0;
    else        ticket <= ticket + 3'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pr_valid_jump_o   <= 1'b0;
      pr_jump_taken_o   <= 1'b0;
      pr_is_comp_o      <= 1'b0;
      pr_rat_id_o       <= '0;
      pr_orig_pc_o      <= '0;
      pr_jump_address_o <= '0;
      pr_ticket_o       <= '0;
      restart_o         <= 1'b0;
      restart_pc_o      <= '0;
    end else begin
      pr_valid_jump_o <= pop;
      restart_o       <= mis;
      if (pop) begin
        pr_jump_taken_o   <= head_tk;
        pr_is_comp_o      <= head_comp;
        pr_rat_id_o       <= head_rat;
        pr_orig_pc_o      <= head_pc;
        pr_jump_address_o <= head_tgt;
        pr_ticket_o       <= ticket;
      end
      if (mis)
        restart_pc_o <= head_tk ? head_tgt : head_pc + (head_comp ? PC_BITS'(2) : PC_BITS'(4));
    end
  end

`ifdef PR_UPDATE_TX_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_updates_o <= '0;
      stat_mispred_o <= '0;
    end else begin
      if (pr_valid_jump_o && (stat_updates_o != 32'hFFFF_FFFF)) stat_updates_o <= stat_updates_o + 32'd1;
      if (restart_o && (stat_mispred_o != 32'hFFFF_FFFF))       stat_mispred_o <= stat_mispred_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pr_update_tx.sv
// Bench for pr_update_tx: directed scenarios plus random traffic checked against a queue-based model.
module tb_pr_update_tx;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush;
  logic [1:0]  res_valid, res_taken, res_pred_taken, res_is_comp;
  logic [3:0]  res_rat_id;
  logic [63:0] res_orig_pc, res_target, res_pred_target;
  logic        res_ready;
  logic        pr_valid_jump, pr_jump_taken, pr_is_comp, restart;
  logic [1:0]  pr_rat_id;
  logic [31:0] pr_orig_pc, pr_jump_address, restart_pc;
  logic [2:0]  pr_ticket;
`ifdef PR_UPDATE_TX_STATS_EN
  logic [31:0] stat_updates, stat_mispred;
`endif

  pr_update_tx #(.DEPTH(DEPTH), .PC_BITS(32), .IN_WIDTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .res_valid_i(res_valid), .res_ready_o(res_ready),
    .res_orig_pc_i(res_orig_pc), .res_target_i(res_target),
    .res_taken_i(res_taken), .res_pred_taken_i(res_pred_taken),
    .res_pred_target_i(res_pred_target), .res_is_comp_i(res_is_comp),
    .res_rat_id_i(res_rat_id), .flush_i(flush),
    .pr_valid_jump_o(pr_valid_jump), .pr_jump_taken_o(pr_jump_taken),
    .pr_is_comp_o(pr_is_comp), .pr_rat_id_o(pr_rat_id),
    .pr_orig_pc_o(pr_orig_pc), .pr_jump_address_o(pr_jump_address),
    .pr_ticket_o(pr_ticket), .restart_o(restart), .restart_pc_o(restart_pc)
`ifdef PR_UPDATE_TX_STATS_EN
    , .stat_updates_o(stat_updates), .stat_mispred_o(stat_mispred)
`endif
  );

  typedef struct {
    logic [31:0] pc, tgt, ptgt;
    logic        tk, ptk, comp;
    logic [1:0]  rat;
  } rec_t;

  int   n_tests, n_fail;
  rec_t cur [2];
  rec_t idle_r;
  rec_t mq [$];
  int   ticket_m;
  logic        e_valid, e_taken, e_comp, e_restart;
  logic [1:0]  e_rat;
  logic [31:0] e_pc, e_addr, e_rpc;
  logic [2:0]  e_ticket;

  function automatic rec_t mk(input logic [31:0] pc, input logic [31:0] tgt, input logic tk,
                              input logic ptk, input logic [31:0] ptgt, input logic comp,
                              input logic [1:0] rat);
    rec_t r;
    r.pc = pc; r.tgt = tgt; r.tk = tk; r.ptk = ptk; r.ptgt = ptgt; r.comp = comp; r.rat = rat;
    return r;
  endfunction

  function automatic rec_t ok_rec(input logic [31:0] pc);
    return mk(pc, pc + 32'h40, 1'b0, 1'b0, 32'h0, 1'b0, pc[3:2]);
  endfunction

  function automatic rec_t rand_rec(input int mis_pct);
    rec_t r;
    r.pc   = $urandom;
    r.tgt  = $urandom;
    r.tk   = 1'($urandom_range(0, 1));
    r.comp = 1'($urandom_range(0, 1));
    r.rat  = 2'($urandom_range(0, 3));
    if (int'($urandom_range(0, 99)) < mis_pct) begin
      if ($urandom_range(0, 1) == 1) begin
        r.ptk = ~r.tk; r.ptgt = $urandom;
      end else begin
        r.tk = 1'b1; r.ptk = 1'b1; r.ptgt = r.tgt ^ 32'h10;
      end
    end else begin
      r.ptk  = r.tk;
      r.ptgt = r.tk ? r.tgt : 32'($urandom);
    end
    return r;
  endfunction

  task automatic drive(input logic [1:0] v, input rec_t a, input rec_t b);
    cur[0] = a; cur[1] = b;
    res_valid       = v;
    res_orig_pc     = {b.pc, a.pc};
    res_target      = {b.tgt, a.tgt};
    res_pred_target = {b.ptgt, a.ptgt};
    res_taken       = {b.tk, a.tk};
    res_pred_taken  = {b.ptk, a.ptk};
    res_is_comp     = {b.comp, a.comp};
    res_rat_id      = {b.rat, a.rat};
  endtask

  task automatic model_reset();
    mq.delete();
    ticket_m = 0;
    e_valid = 0; e_taken = 0; e_comp = 0; e_restart = 0; e_rat = 0;
    e_pc = 0; e_addr = 0; e_rpc = 0; e_ticket = 0;
  endtask

  // One clock of the reference: ready is judged on the queue before this cycle's pop.
  task automatic model_step();
    rec_t r;
    bit   mis, rdy;
    if (!rst_n) begin
      model_reset();
      return;
    end
    rdy = (mq.size() <= DEPTH - 2);
    e_valid = 0; e_restart = 0; mis = 0;
    if (flush) begin
      mq.delete();
    end else begin
      if (mq.size() > 0) begin
        r = mq.pop_front();
        e_valid = 1; e_taken = r.tk; e_comp = r.comp; e_rat = r.rat;
        e_pc = r.pc; e_addr = r.tgt; e_ticket = 3'(ticket_m);
        ticket_m = (ticket_m + 1) % 8;
        mis = (r.tk != r.ptk) || (r.tk && (r.tgt != r.ptgt));
        if (mis) begin
          e_restart = 1;
          e_rpc = r.tk ? r.tgt : r.pc + (r.comp ? 32'd2 : 32'd4);
          mq.delete();
        end
      end
      if (!mis && rdy)
        for (int s = 0; s < 2; s++) if (res_valid[s]) mq.push_back(cur[s]);
    end
  endtask

  task automatic clock_step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [104:0] dut_vec();
    return {pr_valid_jump, pr_jump_taken, pr_is_comp, pr_rat_id, pr_orig_pc,
            pr_jump_address, pr_ticket, restart, restart_pc};
  endfunction

  function automatic logic [104:0] exp_vec();
    return {e_valid, e_taken, e_comp, e_rat, e_pc, e_addr, e_ticket, e_restart, e_rpc};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0;
    drive(2'b00, idle_r, idle_r);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    n_tests++;
    if (dut_vec() !== 105'd0) begin
      n_fail++; $display("FAIL reset_outputs act=%h exp=0", dut_vec());
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    n_tests++;
    if ({res_ready, dut_vec()} !== {1'b1, 105'd0}) begin
      n_fail++; $display("FAIL reset_release ready=%b out=%h exp ready=1 out=0", res_ready, dut_vec());
    end
  endtask

  task automatic test_single();
    drive(2'b01, mk(32'h100, 32'h180, 1'b0, 1'b0, 32'h0, 1'b0, 2'd1), idle_r);
    for (int k = 0; k < 4; k++) begin
      clock_step();
      if (k == 0) drive(2'b00, idle_r, idle_r);
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL single_model k=%0d act=%h exp=%h", k, dut_vec(), exp_vec());
      end
      if (k == 1) begin
        n_tests++;
        if ({pr_valid_jump, pr_orig_pc, pr_ticket, restart} !== {1'b1, 32'h100, 3'd0, 1'b0}) begin
          n_fail++; $display("FAIL single_latency act v=%b pc=%h t=%0d r=%b exp v=1 pc=100 t=0 r=0",
                             pr_valid_jump, pr_orig_pc, pr_ticket, restart);
        end
      end
    end
  endtask

  task automatic test_fill();
    int sent, got, bad_order, nrec;
    bit seen_low, acc;
    logic [1:0] v;
    do_reset();
    nrec = 18; sent = 0; got = 0; bad_order = 0; seen_low = 0;
    for (int k = 0; k < 60; k++) begin
      v = (nrec - sent >= 2) ? 2'b11 : ((nrec - sent == 1) ? 2'b01 : 2'b00);
      drive(v, ok_rec(32'h1000 + 32'(4 * sent)), ok_rec(32'h1000 + 32'(4 * (sent + 1))));
      n_tests++;
      if (res_ready !== (mq.size() <= DEPTH - 2)) begin
        n_fail++; $display("FAIL fill_ready k=%0d act=%b exp=%b", k, res_ready, mq.size() <= DEPTH - 2);
      end
      if (!res_ready) seen_low = 1;
      acc = res_ready;
      clock_step();
      if (acc) sent += (v == 2'b11) ? 2 : ((v == 2'b01) ? 1 : 0);
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL fill_model k=%0d act=%h exp=%h", k, dut_vec(), exp_vec());
      end
      if (pr_valid_jump) begin
        if (pr_orig_pc !== 32'h1000 + 32'(4 * got) || pr_ticket !== 3'(got)) bad_order++;
        got++;
      end
    end
    n_tests++;
    if ({seen_low, got, bad_order} !== {1'b1, nrec, 32'd0}) begin
      n_fail++; $display("FAIL fill_summary seen_low=%b got=%0d bad=%0d exp seen_low=1 got=%0d bad=0",
                         seen_low, got, bad_order, nrec);
    end
  endtask

  task automatic test_mispredict();
    rec_t pa [3], pb [3];
    int n_restart, bad;
    logic [31:0] rpc_seen;
    pa[0] = ok_rec(32'h500); pb[0] = ok_rec(32'h504);
    pa[1] = mk(32'h600, 32'h2000, 1'b1, 1'b0, 32'h0, 1'b0, 2'd2); pb[1] = ok_rec(32'h700);
    pa[2] = ok_rec(32'h704); pb[2] = ok_rec(32'h708);
    n_restart = 0; bad = 0; rpc_seen = 0;
    for (int k = 0; k < 9; k++) begin
      if (k < 3) drive(2'b11, pa[k], pb[k]);
      else       drive(2'b00, idle_r, idle_r);
      clock_step();
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL mispred_model k=%0d act=%h exp=%h", k, dut_vec(), exp_vec());
      end
      if (restart) begin
        n_restart++;
        rpc_seen = restart_pc;
        if (!pr_valid_jump || pr_orig_pc !== 32'h600) bad++;
      end
      if (pr_valid_jump && pr_orig_pc inside {32'h700, 32'h704, 32'h708}) bad++;
    end
    n_tests++;
    if ({n_restart, rpc_seen, bad} !== {32'd1, 32'h2000, 32'd0}) begin
      n_fail++; $display("FAIL mispred_summary restarts=%0d rpc=%h bad=%0d exp 1 2000 0",
                         n_restart, rpc_seen, bad);
    end
  endtask

  task automatic test_restart_pc();
    rec_t rc [2];
    logic [31:0] erp [2];
    rc[0] = mk(32'h3E, 32'h40, 1'b0, 1'b1, 32'h40, 1'b1, 2'd0);        erp[0] = 32'h40;
    rc[1] = mk(32'hFFFF_FFFC, 32'h80, 1'b0, 1'b1, 32'h80, 1'b0, 2'd3); erp[1] = 32'h0;
    for (int c = 0; c < 2; c++) begin
      if (c == 0) drive(2'b01, rc[c], idle_r);
      else        drive(2'b10, idle_r, rc[c]);
      for (int k = 0; k < 4; k++) begin
        clock_step();
        if (k == 0) drive(2'b00, idle_r, idle_r);
        n_tests++;
        if (dut_vec() !== exp_vec()) begin
          n_fail++; $display("FAIL rpc_model c=%0d k=%0d act=%h exp=%h", c, k, dut_vec(), exp_vec());
        end
        if (k == 1 || k == 2) begin
          n_tests++;
          if ({restart, restart_pc} !== {(k == 1), erp[c]}) begin
            n_fail++; $display("FAIL rpc_value c=%0d k=%0d act r=%b pc=%h exp r=%b pc=%h",
                               c, k, restart, restart_pc, k == 1, erp[c]);
          end
        end
      end
    end
  endtask

  task automatic test_flush();
    int t_start, extra;
    t_start = ticket_m;
    extra = 0;
    for (int k = 0; k < 3; k++) begin
      drive(2'b11, ok_rec(32'h900 + 32'(16 * k)), ok_rec(32'h904 + 32'(16 * k)));
      clock_step();
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL flush_fill k=%0d act=%h exp=%h", k, dut_vec(), exp_vec());
      end
    end
    flush = 1'b1;
    drive(2'b11, ok_rec(32'h980), ok_rec(32'h984));
    clock_step();
    flush = 1'b0;
    drive(2'b00, idle_r, idle_r);
    for (int k = 0; k < 5; k++) begin
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL flush_model k=%0d act=%h exp=%h", k, dut_vec(), exp_vec());
      end
      if (pr_valid_jump) extra++;
      clock_step();
    end
    n_tests++;
    if (extra != 0) begin
      n_fail++; $display("FAIL flush_quiet act=%0d updates exp=0", extra);
    end
    drive(2'b01, ok_rec(32'h9A0), idle_r);
    clock_step();
    drive(2'b00, idle_r, idle_r);
    clock_step();
    n_tests++;
    if ({pr_valid_jump, pr_orig_pc, pr_ticket} !== {1'b1, 32'h9A0, 3'(t_start + 2)}) begin
      n_fail++; $display("FAIL flush_ticket act v=%b pc=%h t=%0d exp v=1 pc=9a0 t=%0d",
                         pr_valid_jump, pr_orig_pc, pr_ticket, (t_start + 2) % 8);
    end
  endtask

  task automatic test_reset_mid();
    int stale;
    stale = 0;
    for (int k = 0; k < 4; k++) begin
      drive(2'b11, ok_rec(32'hA00 + 32'(16 * k)), ok_rec(32'hA04 + 32'(16 * k)));
      clock_step();
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({res_ready, dut_vec()} !== {1'b1, 105'd0}) begin
      n_fail++; $display("FAIL rstmid_async ready=%b out=%h exp ready=1 out=0", res_ready, dut_vec());
    end
    drive(2'b00, idle_r, idle_r);
    model_reset();
    clock_step();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      clock_step();
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL rstmid_model k=%0d act=%h exp=%h", k, dut_vec(), exp_vec());
      end
      if (pr_valid_jump) stale++;
    end
    drive(2'b01, ok_rec(32'hB00), idle_r);
    clock_step();
    drive(2'b00, idle_r, idle_r);
    clock_step();
    n_tests++;
    if ({stale, pr_valid_jump, pr_orig_pc, pr_ticket} !== {32'd0, 1'b1, 32'hB00, 3'd0}) begin
      n_fail++; $display("FAIL rstmid_after stale=%0d v=%b pc=%h t=%0d exp 0 1 b00 0",
                         stale, pr_valid_jump, pr_orig_pc, pr_ticket);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      flush = ($urandom_range(0, 99) < 4);
      drive(2'($urandom_range(0, 3)), rand_rec(12), rand_rec(12));
      n_tests++;
      if (res_ready !== (mq.size() <= DEPTH - 2)) begin
        n_fail++; $display("FAIL rand_ready k=%0d act=%b exp=%b", k, res_ready, mq.size() <= DEPTH - 2);
      end
      clock_step();
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL rand_model k=%0d act=%h exp=%h", k, dut_vec(), exp_vec());
      end
    end
    flush = 1'b0;
    drive(2'b00, idle_r, idle_r);
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    idle_r = mk(32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 2'd0);
    rst_n = 1'b0; flush = 1'b0;
    drive(2'b00, idle_r, idle_r);
    model_reset();
    test_reset();
    test_single();
    test_fill();
    test_mispredict();
    test_restart_pc();
    test_flush();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pr_update_tx.md
Name: pr_update_tx

Overview:
Transmit side of the predictor-update channel into the IF stage. Accepts up to two resolved branch records per cycle from the branch resolution logic and buffers them in order. Serialises them as one predictor_update per cycle: valid_jump, jump_taken, is_comp, rat_id, orig_pc, jump_address, ticket. On a misprediction it raises a one-cycle invalid_prediction restart with the corrected PC and squashes younger wrong-path records.

Parameters:
DEPTH, 8, record FIFO entries (power of 2, >=4)
PC_BITS, 32, PC / address width
IN_WIDTH, 2, resolved records accepted per cycle (fixed 2; matches INSTR_COUNT)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
res_valid_i  in  2  per-slot record valid; slot0 older than slot1
res_ready_o  out  1  both slots accepted this cycle
res_orig_pc_i  in  2xPC_BITS  branch PC per slot
res_target_i  in  2xPC_BITS  resolved target per slot
res_taken_i  in  2  resolved direction per slot
res_pred_taken_i  in  2  direction predicted by IF
res_pred_target_i  in  2xPC_BITS  target predicted by IF
res_is_comp_i  in  2  compressed (2-byte) instruction
res_rat_id_i  in  2x2  RAT id per slot
flush_i  in  1  synchronous queue clear
pr_valid_jump_o  out  1  update valid
pr_jump_taken_o  out  1  resolved direction
pr_is_comp_o  out  1  compressed flag
pr_rat_id_o  out  2  RAT id
pr_orig_pc_o  out  PC_BITS  branch PC
pr_jump_address_o  out  PC_BITS  resolved target
pr_ticket_o  out  3  update sequence number
restart_o  out  1  invalid_prediction restart pulse
restart_pc_o  out  PC_BITS  corrected fetch PC

Behaviour:
- Reset (rst_n low, async): FIFO empty; count=0; ticket=0; all outputs 0. res_ready_o=1 once reset is released. A record mid-queue is lost on reset.
- Acceptance: res_ready_o = (registered count <= DEPTH-2); combinational from state only.
- Push: on res_ready_o & valid, push valid slots in order slot0 then slot1. A slot1-only push is legal and is stored as one record. Invalid slots are skipped.
- Pop: when count>0 and no flush, pop the head every cycle. There is no output backpressure; IF always accepts.
- Output timing: registered. Record popped in cycle N drives pr_* in cycle N+1 with pr_valid_jump_o=1. pr_valid_jump_o=0 and the other pr_* fields hold their last values when nothing was popped.
- Push-to-output latency: 2 cycles into an empty FIFO; the push registers in N and the record appears on pr_* in N+2.
- Ticket: pr_ticket_o = internal 3-bit counter at pop time. Counter increments per emitted update and wraps 7->0. Flush does not reset it.
- Mispredict test on the popped record: mis = (taken != pred_taken) | (taken & (target != pred_target)).
- On mis:
  - restart_o=1 for exactly one cycle, aligned with that record's pr_valid_jump_o.
  - restart_pc_o = taken ? target : orig_pc + (is_comp ? 2 : 4), modulo 2^PC_BITS.
  - All entries behind the head are discarded in the pop cycle, and any push in that same cycle is dropped. count becomes 0.
- flush_i: clears the FIFO; no pop and no push that cycle. It has priority over push, pop and mispredict. The output already registered from the previous pop still appears.
- Simultaneous push+pop: pop is from the old head. count_next = count - pop + pushes.
- Full: count=DEPTH-1 or DEPTH gives res_ready_o=0; the producer holds. Pointer wrap is modulo DEPTH.
- restart_o defaults to 0. restart_pc_o holds its last value.

Optional Feature:
PR_UPDATE_TX_STATS_EN: when defined, adds outputs stat_updates_o[31:0] and stat_mispred_o[31:0]. They count emitted updates and restarts, saturate at 0xFFFFFFFF, and reset to 0. When undefined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset release, then one not-taken record (pc 0x100, pred_taken=0, is_comp=0) -> 2 cycles later pr_valid_jump_o=1, orig_pc 0x100, ticket 0, restart_o=0.
- Push 9 correctly predicted records, 2 per cycle -> res_ready_o drops at count>=7; outputs are in order, one per cycle; tickets run 0..7,0.
- Predicted not-taken, actually taken to 0x2000 -> restart_o=1 for one cycle with restart_pc 0x2000; 3 queued younger records are never emitted.
- Predicted taken to 0x40, actually not taken, pc 0x3E, is_comp=1 -> restart_pc_o=0x40; pc 0xFFFFFFFC, is_comp=0 -> restart_pc_o=0x0.
- flush_i with 4 queued and a simultaneous push -> no further pr_valid_jump_o; next record uses the ticket continuing from the last emitted one.
- Reset asserted with 5 queued -> all outputs 0 immediately; after release, no stale updates and ticket restarts at 0.
